if_id_stage: RTL and testbench

Parametrised, handshaked fetch-to-decode pipeline register that succeeds the plain enable-gated IF/ID latch. It carries instruction word and PC with a valid bit and uses valid/ready flow control in both directions. A two-entry skid buffer keeps `in_ready` registered and breaks the combinational ready path. A flush input squashes all held entries and presents a configurable NOP. It sits between the fetch unit and the decoder.

---
 rtl/if_id_pkg.sv | 11 +
 rtl/skid_buf.sv | 95 +++++++++
 rtl/if_id_stage.sv | 50 +++++
 tb/tb_if_id_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
// Shared fetch/decode definitions: occupancy-coded buffer states
// and the default NOP (addi x0, x0, 0) used by pipeline stages.
package if_id_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

endpackage

// File: rtl/skid_buf.sv
// Generic two-entry valid/ready skid buffer with flush.
// Ports: in_* upstream side, out_* downstream side, occupancy 0..2.
module skid_buf
  import if_id_pkg::*;
#(
  parameter int W       = 64,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  logic [1:0]   state;
  logic [1:0]   state_nx;
  logic [W-1:0] main_q;
  logic [W-1:0] main_nx;
  logic [W-1:0] skid_q;
  logic [W-1:0] skid_nx;
  logic         rdy_q;
  logic         xin;
  logic         xout;

  // State encoding doubles as the live-entry count.
  assign occupancy = state;
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign xin       = in_valid & in_ready;
  assign xout      = out_valid & out_ready;

  if (SKID_EN) begin : g_reg_rdy
    assign in_ready = rdy_q;
  end else begin : g_comb_rdy
    assign in_ready = out_ready | ~out_valid;
  end

  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    if (flush) begin
      state_nx = ST_EMPTY;
      main_nx  = '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (xin) begin
            main_nx  = in_data;
            state_nx = ST_FULL;
          end
        end
        ST_FULL: begin
          if (xin && xout) begin
            main_nx = in_data;
          end else if (xin) begin
            skid_nx  = in_data;
            state_nx = ST_SKID;
          end else if (xout) begin
            // main keeps its payload so the PC stays visible.
            state_nx = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (xout) begin
            main_nx  = skid_q;
            state_nx = ST_FULL;
          end
        end
        default: state_nx = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      state  <= state_nx;
      main_q <= main_nx;
      skid_q <= skid_nx;
      rdy_q  <= (state_nx != ST_SKID);
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Handshaked IF/ID pipeline register around a skid buffer.
// Ports: instr_in/pc_in in, instr_out/pc_out out, occupancy.
module if_id_stage
  import if_id_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 32,
  parameter logic [D_WIDTH-1:0] NOP_INSTR =
    D_WIDTH'(NOP_INSTR_DEF),
  parameter bit SKID_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] instr_in,
  input  logic [A_WIDTH-1:0] pc_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] instr_out,
  output logic [A_WIDTH-1:0] pc_out,
  output logic [1:0]         occupancy
);

  localparam int W = D_WIDTH + A_WIDTH;

  logic [W-1:0] head;

  skid_buf #(
    .W       (W),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({pc_in, instr_in}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head),
    .occupancy (occupancy)
  );

  // Idle stage shows a NOP; PC holds until reset/flush clears it.
  assign instr_out = out_valid ? head[D_WIDTH-1:0] : NOP_INSTR;
  assign pc_out    = head[W-1:D_WIDTH];

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage, both SKID_EN settings.
// Directed reset/stream/back-pressure/flush, then random traffic.
module tb_if_id_stage;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    localparam bit SK = (g == 0);

    logic        rst, flush, in_valid, in_ready;
    logic        out_valid, out_ready;
    logic [31:0] instr_in, pc_in, instr_out, pc_out;
    logic [1:0]  occupancy;
    logic [63:0] sb[$];
    logic [31:0] last_pc = '0;
    bit          done = 1'b0;

    if_id_stage #(.SKID_EN(SK)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr_in  (instr_in),
      .pc_in     (pc_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .instr_out (instr_out),
      .pc_out    (pc_out),
      .occupancy (occupancy)
    );

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s[skid_en=%0d]: got %h expected %h",
                 nm, SK, act, exp);
      end
    endtask

    // One clock cycle: check idle-state outputs, drive inputs,
    // record accepted entries, apply flush/reset to the model.
    task automatic step(input logic r, fl, iv,
                        input logic [31:0] ic, pc,
                        input logic ordy,
                        output logic acc);
      int   n;
      logic er;
      @(negedge clk);
      n = sb.size();
      chk("occupancy", 64'(occupancy), 64'(n));
      chk("out_valid", 64'(out_valid), 64'(n != 0));
      if (n == 0) begin
        chk("instr_idle", 64'(instr_out), 64'h13);
        chk("pc_idle", 64'(pc_out), 64'(last_pc));
      end
      rst = r; flush = fl; in_valid = iv;
      instr_in = ic; pc_in = pc; out_ready = ordy;
      #1;
      er = SK ? (n < 2) : (ordy || n == 0);
      chk("in_ready", 64'(in_ready), 64'(er));
      acc = iv && in_ready && !fl && !r;
      if (acc) sb.push_back({pc, ic});
      #1;
      if (fl || r) begin
        sb.delete();
        last_pc = '0;
      end
    endtask

    always @(negedge clk) begin
      #1;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out[skid_en=%0d]: got %h expected none",
                   SK, {pc_out, instr_out});
        end else begin
          automatic logic [63:0] e = sb.pop_front();
          chk("out_data", {pc_out, instr_out}, e);
          last_pc = e[63:32];
        end
      end
    end

    initial begin
      logic        a, hold, iv, fl, rr;
      logic [31:0] ci, cp;
      logic [31:0] bi[3];
      int          idx;

      rst = 1; flush = 0; in_valid = 1; out_ready = 0;
      instr_in = 32'hdead_beef; pc_in = 32'h44;
      repeat (2) @(negedge clk);

      // streaming
      for (int i = 0; i < 3; i++) begin
        step(0, 0, 1, 32'hA + i, 32'(4 * i), 1, a);
        chk("stream_acc", 64'(a), 64'd1);
      end
      repeat (3) step(0, 0, 0, 0, 0, 1, a);

      // back-pressure, then release
      bi = '{32'h100, 32'h104, 32'h108};
      idx = 0;
      for (int i = 0; i < 5; i++) begin
        step(0, 0, idx < 3, 32'h1 + idx, bi[idx % 3], 0, a);
        if (a) idx++;
      end
      chk("bp_accepted", 64'(idx), SK ? 64'd2 : 64'd1);
      for (int t = 0; t < 20 && idx < 3; t++) begin
        step(0, 0, 1, 32'h1 + idx, bi[idx], 1, a);
        if (a) idx++;
      end
      chk("bp_all_sent", 64'(idx), 64'd3);
      repeat (4) step(0, 0, 0, 0, 0, 1, a);

      // fill, then flush together with a new input
      step(0, 0, 1, 32'h7, 32'h300, 0, a);
      step(0, 0, 1, 32'h8, 32'h304, 0, a);
      step(0, 1, 1, 32'h9, 32'h200, 0, a);
      chk("flush_acc", 64'(a), 64'd0);
      repeat (3) step(0, 0, 0, 0, 0, 1, a);

      // random traffic
      hold = 0; iv = 0; ci = 0; cp = 0;
      for (int c = 0; c < 4000; c++) begin
        if (!hold) begin
          ci = $urandom;
          cp = $urandom & 32'hffff_fffc;
          iv = ($urandom_range(0, 9) < 7);
        end
        fl = ($urandom_range(0, 31) == 0);
        rr = ($urandom_range(0, 255) == 0);
        step(rr, fl, iv, ci, cp, $urandom_range(0, 9) < 6, a);
        hold = iv && !a;
      end
      repeat (4) step(0, 0, 0, 0, 0, 1, a);
      done = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(u[0].done && u[1].done) && t < 50000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 50000) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d cycles expected < 50000", t);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
